// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and frame constants for the program loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HCNT  = 3'd1,
    HADDR = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian 4-byte word assembler with running XOR checksum
module byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [7:0]  csum,
  output logic        last
);

  logic [1:0] idx;

  assign last = (idx == 2'd3);

  // word is not cleared by clr: it only feeds the memory while a full word is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word <= '0;
      csum <= '0;
      idx  <= '0;
    end else if (clr) begin
      csum <= '0;
      idx  <= '0;
    end else if (shift) begin
      word <= {word[23:0], byte_in};
      csum <= csum ^ byte_in;
      idx  <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader driving the instruction memory write port
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         AW   = 8,
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] csum;
  logic       last;
  logic       accept;
  logic       is_sync;

  assign in_ready = (state != WRITE);
  assign accept   = in_valid & in_ready;
  assign is_sync  = (in_data == SYNC);

  byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state == HADDR) && accept),
    .shift   ((state == DATA) && accept),
    .byte_in (in_data),
    .word    (mem_wdata),
    .csum    (csum),
    .last    (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_sync) state_nxt = HCNT;
      HCNT:    if (accept) state_nxt = HADDR;
      HADDR:   if (accept) state_nxt = DATA;
      DATA:    if (accept && last) state_nxt = WRITE;
      WRITE:   state_nxt = (cnt == 8'd0) ? CSUM : DATA;
      CSUM:    if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= (state_nxt == WRITE);
      done   <= 1'b0;
      case (state)
        IDLE: if (accept && is_sync) begin
          cpu_hold <= 1'b1;
          err      <= 1'b0;
        end
        HCNT:  if (accept) cnt <= in_data;
        HADDR: if (accept) mem_addr <= AW'(in_data);
        // address advances after the write cycle so it is stable while mem_we is high
        WRITE: begin
          mem_addr <= mem_addr + AW'(1);
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        CSUM: if (accept) begin
          if (in_data == csum) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt = 0;
  int          nrdy_cnt = 0;
  int          we_back2back = 0;
  logic        we_prev = 1'b0;

  imem_loader #(.AW(8), .SYNC(8'hA5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (mem_we && we_prev) we_back2back++;
    we_prev = mem_we;
    if (done) done_cnt++;
    if (!in_ready) nrdy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input logic [7:0] b);
    logic took;
    int   n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      took = in_ready;
      @(negedge clk);
      n++;
    end while (!took && n < 20);
    in_valid = 1'b0;
    if (!took) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  logic [31:0] exp_w[16];
  logic [7:0]  cs;
  int          d0;
  int          i0;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mem_we",   {31'd0, mem_we},   32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata",    mem_wdata,         32'd0);
    check("rst_hold",     {31'd0, cpu_hold}, 32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    reset_n = 1'b1;
    idle(2);

    // single-word frame
    clear_log();
    send(8'hA5); send(8'h00); send(8'h10);
    send(8'h20); send(8'h00); send(8'h00); send(8'h01);
    check("a_hold_before_csum", {31'd0, cpu_hold}, 32'd1);
    send(8'h21);
    check("a_done_pulse", {31'd0, done},     32'd1);
    check("a_hold_low",   {31'd0, cpu_hold}, 32'd0);
    idle(1);
    check("a_done_one_cycle", {31'd0, done}, 32'd0);
    idle(1);
    check("a_wr_count", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("a_addr", {24'd0, wr_addr[0]}, 32'h10);
      check("a_data", wr_data[0], 32'h20000001);
    end

    // three words at 0xFE, continuous valid, wraps to 0x00
    clear_log();
    nrdy_cnt = 0;
    d0 = done_cnt;
    send(8'hA5); send(8'h02); send(8'hFE);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h66);
    idle(2);
    check("b_wr_count", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      check("b_addr0", {24'd0, wr_addr[0]}, 32'hFE);
      check("b_addr1", {24'd0, wr_addr[1]}, 32'hFF);
      check("b_addr2", {24'd0, wr_addr[2]}, 32'h00);
      check("b_data0", wr_data[0], 32'h01020304);
      check("b_data1", wr_data[1], 32'h10203040);
      check("b_data2", wr_data[2], 32'hDEADBEEF);
    end
    check("b_nrdy_cycles", nrdy_cnt, 32'd3);
    check("b_done", done_cnt - d0, 32'd1);
    check("b_err",  {31'd0, err}, 32'd0);

    // same frame with a bad checksum
    clear_log();
    d0 = done_cnt;
    send(8'hA5); send(8'h02); send(8'hFE);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h67);
    check("c_err_set",  {31'd0, err},      32'd1);
    check("c_hold",     {31'd0, cpu_hold}, 32'd1);
    idle(2);
    check("c_wr_count", wr_addr.size(), 32'd3);
    check("c_no_done",  done_cnt - d0, 32'd0);
    check("c_err_sticky", {31'd0, err}, 32'd1);

    // good frame afterwards clears err at SYNC
    clear_log();
    d0 = done_cnt;
    send(8'hA5);
    check("d_err_cleared", {31'd0, err}, 32'd0);
    send(8'h00); send(8'h20);
    send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
    send(8'h30);
    check("d_hold_low", {31'd0, cpu_hold}, 32'd0);
    idle(2);
    check("d_done", done_cnt - d0, 32'd1);
    if (wr_addr.size() == 1) check("d_data", wr_data[0], 32'hCAFEBABE);
    else check("d_wr_count", wr_addr.size(), 32'd1);

    // leading garbage, SYNC value inside data
    clear_log();
    d0 = done_cnt;
    send(8'h00); send(8'hFF); send(8'h12);
    idle(1);
    check("e_garbage_no_write", wr_addr.size(), 32'd0);
    send(8'hA5); send(8'h01); send(8'h30);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h07);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'hAA);
    idle(2);
    check("e_wr_count", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check("e_addr0", {24'd0, wr_addr[0]}, 32'h30);
      check("e_data0", wr_data[0], 32'hA5000007);
      check("e_addr1", {24'd0, wr_addr[1]}, 32'h31);
      check("e_data1", wr_data[1], 32'h12345678);
    end
    check("e_done", done_cnt - d0, 32'd1);

    // sixteen words with random valid gaps
    clear_log();
    d0 = done_cnt;
    we_back2back = 0;
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin
      exp_w[i] = {8'(i) ^ 8'h5A, 8'(i * 7), 8'hA5, 8'(255 - i)};
      cs = cs ^ exp_w[i][31:24] ^ exp_w[i][23:16] ^ exp_w[i][15:8] ^ exp_w[i][7:0];
    end
    send(8'hA5); idle($urandom_range(0, 3));
    send(8'h0F); idle($urandom_range(0, 3));
    send(8'h80);
    for (int i = 0; i < 16; i++) begin
      for (int k = 3; k >= 0; k--) begin
        idle($urandom_range(0, 3));
        send(exp_w[i][k*8 +: 8]);
      end
    end
    idle($urandom_range(0, 3));
    send(cs);
    idle(2);
    check("f_wr_count", wr_addr.size(), 32'd16);
    if (wr_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("f_addr%0d", i), {24'd0, wr_addr[i]}, 32'(8'h80 + i));
        check($sformatf("f_data%0d", i), wr_data[i], exp_w[i]);
      end
    end
    check("f_we_single", we_back2back, 32'd0);
    check("f_done", done_cnt - d0, 32'd1);

    // reset mid-word
    clear_log();
    d0 = done_cnt;
    send(8'hA5); send(8'h00); send(8'h50); send(8'h11); send(8'h22);
    reset_n = 1'b0;
    #1;
    check("g_in_ready", {31'd0, in_ready}, 32'd1);
    check("g_mem_we",   {31'd0, mem_we},   32'd0);
    check("g_addr",     {24'd0, mem_addr}, 32'd0);
    check("g_wdata",    mem_wdata,         32'd0);
    check("g_hold",     {31'd0, cpu_hold}, 32'd1);
    check("g_done",     {31'd0, done},     32'd0);
    check("g_err",      {31'd0, err},      32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    check("g_no_write", wr_addr.size(), 32'd0);
    send(8'hA5); send(8'h00); send(8'h51);
    send(8'h99); send(8'h88); send(8'h77); send(8'h66);
    send(8'h00);
    idle(2);
    check("h_wr_count", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("h_addr", {24'd0, wr_addr[0]}, 32'h51);
      check("h_data", wr_data[0], 32'h99887766);
    end
    check("h_done", done_cnt - d0, 32'd1);
    check("h_hold", {31'd0, cpu_hold}, 32'd0);

    i0 = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
